// File: rtl/fpdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_iter
//  Purpose  : Iterative radix-2 restoring single-precision divider, res = a/b,
//             one quotient bit per clock, fixed 27-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module fpdiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] res
);

    localparam int QBITS = 26;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sign;
    logic [7:0]         r_exp;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic [4:0]         r_cnt;
    logic               r_za;
    logic               r_zb;

    logic               w_ge;
    logic [24:0]        w_rem_sub;
    logic [22:0]        w_f;
    logic               w_r;
    logic [7:0]         w_exp_pre;
    logic               w_carry;
    logic [22:0]        w_frac;
    logic [7:0]         w_exp_fin;
    logic [31:0]        w_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == 5'(QBITS - 1)) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Restoring step: the remainder always stays below 2*mb, so 25 bits suffice.
    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_mb});
        w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    end

    // q[25] is the integer bit; a quotient below 1.0 needs one left shift.
    always_comb begin
        if (r_q[QBITS-1]) begin
            w_f       = r_q[24:2];
            w_r       = r_q[1];
            w_exp_pre = r_exp;
        end else begin
            w_f       = r_q[23:1];
            w_r       = r_q[0];
            w_exp_pre = r_exp - 8'd1;
        end
        w_carry   = w_r & (&w_f);
        w_frac    = w_carry ? 23'd0 : (w_f + 23'(w_r));
        w_exp_fin = w_carry ? (w_exp_pre + 8'd1) : w_exp_pre;
        if (r_zb) begin
            w_res = {r_sign, 8'hFF, 23'd0};
        end else if (r_za) begin
            w_res = 32'd0;
        end else begin
            w_res = {r_sign, w_exp_fin, w_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            dz     <= 1'b0;
            res    <= 32'd0;
            r_sign <= 1'b0;
            r_exp  <= 8'd0;
            r_mb   <= 24'd0;
            r_rem  <= 25'd0;
            r_q    <= '0;
            r_cnt  <= 5'd0;
            r_za   <= 1'b0;
            r_zb   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= a[31] ^ b[31];
                        r_exp  <= a[30:23] - b[30:23] + 8'd127;
                        r_mb   <= {1'b1, b[22:0]};
                        r_rem  <= {2'b01, a[22:0]};
                        r_za   <= (a[30:0] == 31'd0);
                        r_zb   <= (b[30:0] == 31'd0);
                        r_q    <= '0;
                        r_cnt  <= 5'd0;
                        busy   <= 1'b1;
                        dz     <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    res  <= w_res;
                    done <= 1'b1;
                    busy <= 1'b0;
                    dz   <= r_zb;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpdiv_iter
//  Purpose  : Scoreboard bench for fpdiv_iter: results, flags, latency,
//             busy behaviour, start-while-busy, back-to-back and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpdiv_iter;

    localparam int LAT    = 27;
    localparam int BUDGET = 40;

    typedef struct packed {
        logic [31:0] res;
        logic        dz;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] res;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    fpdiv_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .res   (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives a one-cycle start and queues the expected outcome.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] eres, input logic edz);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = eres; e.dz = edz; e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a done pulse and returns what was seen.
    task automatic collect(output logic got, output logic [31:0] r,
                           output logic d, output int at);
        got = 1'b0; r = 32'd0; d = 1'b0; at = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; r = res; d = dz; at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, dz, res} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b res=%h required all zero",
                     busy, done, dz, res);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        int   nbusy;
        logic seen;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        nbusy = 0; seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            if (busy) nbusy++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL basic_timeout: no done within %0d cycles", BUDGET);
        end else begin
            n_cmp += 3;
            if (nbusy != LAT) begin
                n_bad++;
                $display("FAIL basic_busy_cycles: got %0d required %0d", nbusy, LAT);
            end
            if (cyc != e.due) begin
                n_bad++;
                $display("FAIL basic_latency: done at %0d required %0d", cyc, e.due);
            end
            if (res !== e.res || dz !== e.dz || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_result: res=%h dz=%b busy=%b required res=%h dz=%b busy=0",
                         res, dz, busy, e.res, e.dz);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || res !== 32'h40400000) begin
            n_bad++;
            $display("FAIL done_pulse: done=%b res=%h required done=0 res held 40400000", done, res);
        end
    endtask

    task automatic test_values();
        logic [31:0] va[6] = '{32'h3F800000, 32'hC0800000, 32'h00000000,
                               32'h3F800000, 32'h00000000, 32'h40400000};
        logic [31:0] vb[6] = '{32'h40400000, 32'h3F000000, 32'h40000000,
                               32'h80000000, 32'h00000000, 32'h40000000};
        logic [31:0] vr[6] = '{32'h3EAAAAAB, 32'hC1000000, 32'h00000000,
                               32'hFF800000, 32'h7F800000, 32'h3FC00000};
        logic        vz[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_t e;
        logic got, d;
        logic [31:0] r;
        int at;
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vr[i], vz[i]);
            collect(got, r, d, at);
            e = sb.pop_front();
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL value%0d_timeout: no done within %0d cycles", i, BUDGET);
            end else if (r !== e.res || d !== e.dz || at != e.due) begin
                n_bad++;
                $display("FAIL value%0d: res=%h dz=%b at=%0d required res=%h dz=%b at=%0d",
                         i, r, d, at, e.res, e.dz, e.due);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic got, d;
        logic [31:0] r;
        int at;
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
        got = 1'b0;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
            start = (k == 5 || k == 20);
            a = 32'h40C00000; b = 32'h40000000;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!got || res !== e.res || cyc != e.due) begin
            n_bad++;
            $display("FAIL ignore_start: got=%b res=%h at=%0d required res=%h at=%0d",
                     got, res, cyc, e.res, e.due);
        end
        // Restart in the very cycle done is high.
        start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = 32'h40400000; e.dz = 1'b0; e.due = cyc + LAT;
        sb.push_back(e);
        collect(got, r, d, at);
        e = sb.pop_front();
        n_cmp++;
        if (!got || r !== e.res || d !== e.dz || at != e.due) begin
            n_bad++;
            $display("FAIL restart_in_done: got=%b res=%h at=%0d required res=%h at=%0d",
                     got, r, at, e.res, e.due);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   ndone;
        logic got, d;
        logic [31:0] r;
        int at;
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd0 || dz !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b done=%b res=%h dz=%b required all zero",
                     busy, done, res, dz);
        end
        ndone = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: %0d busy/done cycles seen required 0", ndone);
        end
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        collect(got, r, d, at);
        e = sb.pop_front();
        n_cmp++;
        if (!got || r !== e.res || d !== e.dz || at != e.due) begin
            n_bad++;
            $display("FAIL after_abort: got=%b res=%h dz=%b at=%0d required res=%h dz=%b at=%0d",
                     got, r, d, at, e.res, e.dz, e.due);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_reset_abort();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpdiv_iter.md
Name: fpdiv_iter

Overview:
- Single-precision IEEE-754 style divider, res = a / b, for the C2 backend FP datapath. It is the inverse operation of the pipelined FP multiplier.
- Iterative radix-2 restoring division, one quotient bit per clock, with a start/busy/done handshake.
- Fixed latency so the scheduler can treat it as a multi-cycle functional unit.
- Same simplified number model as the multiplier: no denormals, no NaN/Inf inputs, 8-bit exponent arithmetic with no overflow/underflow detection.

Parameters:
- QBITS, 26, quotient bits generated: 1 integer + 23 fraction + 1 normalise + 1 round. Fixed, not for override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- a  in  32  dividend, captured at accepted start
- b  in  32  divisor, captured at accepted start
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse; res valid in the same cycle
- dz  out  1  divide-by-zero flag, valid with done, held until next acceptance
- res  out  32  quotient, held until next done

Behaviour:
- Reset: when rst=1 at a clk edge, state goes to IDLE and busy=0, done=0, dz=0, res=0, regardless of any operation in flight. The aborted operation produces no done.
- States:
  - IDLE: on start=1, capture sign=a[31]^b[31], e=a[30:23]-b[30:23]+8'd127 (mod 256), ma={1,a[22:0]}, mb={1,b[22:0]}, za=(a[30:0]==0), zb=(b[30:0]==0). Set rem=ma (25b), q=0, cnt=0, busy=1, dz=0. Go to DIV.
  - DIV: each edge performs one step: ge=(rem>=mb); q<={q[24:0],ge}; rem<=(ge ? rem-mb : rem)<<1; cnt++. After the 26th step go to NORM.
  - NORM: one edge. Write res, set done=1, busy=0, dz=zb. Go to IDLE.
- start while busy is ignored; the captured operands are not disturbed.
- done is cleared on the following edge. A new start may be sampled in the same cycle that done is high.
- Latency: if start is accepted at edge N, done and res are valid in the cycle after edge N+27. Latency is the same for all operands, including zero and divide-by-zero.
- Normalisation in NORM, where q[25] is the integer bit:
  - If q[25]=1: f=q[24:2], r=q[1], exp=e.
  - If q[25]=0: f=q[23:1], r=q[0], exp=e-1.
  - Round half-up: s={1,f}+r, 24 bits plus carry.
  - If the carry is set: fraction=0 and exp=exp+1. Otherwise fraction=s[22:0].
- Result priority:
  - zb → res={sign,8'hFF,23'h0}, dz=1.
  - else za → res=32'h0.
  - else res={sign,exp,fraction}.
- Exponent out-of-range results wrap modulo 256; this is documented and not flagged.
- The sign of an inexact-zero result is not applicable; zero is always emitted as +0.

Test Plan:
- Reset, then a=0x40C00000 (6.0), b=0x40000000 (2.0), start for 1 cycle → busy high 27 cycles; done in the cycle after edge N+27; res=0x40400000, dz=0.
- a=0x3F800000, b=0x40400000 (1/3) → res=0x3EAAAAAB, which exercises the q[25]=0 path and round-up.
- a=0xC0800000 (-4.0), b=0x3F000000 (0.5) → res=0xC1000000. Then a=0x00000000, b=0x40000000 → res=0x00000000, dz=0, same latency.
- a=0x3F800000, b=0x80000000 → res=0xFF800000, dz=1. Then a=0, b=0 → dz=1 and res=0x7F800000, confirming zb takes priority.
- Start accepted with 1.0/3.0; assert start with 6.0/2.0 at cycles 5 and 20 → both ignored; the single done returns 0x3EAAAAAB. Also start again in the done cycle → accepted, second done 28 cycles later.
- Assert rst at cycle 10 of an operation → the next cycle has busy=0, done=0, res=0, and no done pulse ever appears for the aborted operation. A subsequent 6.0/2.0 completes correctly.
